uart_tx_engine: RTL and testbench

//   8N1 UART transmitter with a small write FIFO, the TX counterpart of the CPU's UART receive path.
//   The peripheral bus side pushes bytes; the block serialises them onto UART_TX (LSB first) at the

---
 rtl/uart_tx_engine_pkg.sv | 21 ++
 rtl/uart_tx_engine_fifo.sv | 52 +++++
 rtl/uart_tx_engine.sv | 108 ++++++++++
 tb/tb_uart_tx_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_engine_pkg.sv
// Shared UART definitions: state encodings, default timing, line idle level.
// Reused by both the transmit engine and the receive path.
package uart_tx_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 10417;
    localparam int   DEFAULT_FIFO_AW      = 2;
    localparam logic UART_IDLE_LEVEL      = 1'b1;
    localparam int   UART_DATA_BITS       = 8;

    function automatic logic last_data_bit(input logic [2:0] idx);
        return idx == 3'(UART_DATA_BITS - 1);
    endfunction

endpackage

// File: rtl/uart_tx_engine_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
// Head entry is always visible on dout; occupancy is tracked by count.
module uart_tx_fifo #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the occupancy count, so pointers may wrap freely
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter: write FIFO, frame FSM, baud counter and shifter.
// The line and busy flags are registered one cycle after the FSM state.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = DEFAULT_FIFO_AW
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               UART_TX
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    uart_state_t   state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          line_q;
    logic          line_next;
    logic          busy_q;
    logic          baud_done;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;

    assign tx_ready  = !fifo_full;
    assign push      = tx_valid && tx_ready;
    assign baud_done = baud_cnt == BAUD_LAST;
    assign UART_TX   = line_q;
    assign tx_busy   = busy_q;

    uart_tx_fifo #(
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (sysclk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge sysclk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (!fifo_empty) state_next = START;
            START: if (baud_done) state_next = DATA;
            DATA:  if (baud_done && last_data_bit(bit_idx)) state_next = STOP;
            STOP:  if (baud_done) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // STOP hands straight over to the next START when a byte is waiting
    always_comb begin
        pop       = 1'b0;
        line_next = UART_IDLE_LEVEL;
        unique case (1'b1)
            state == IDLE:  pop = !fifo_empty;
            state == START: line_next = 1'b0;
            state == DATA:  line_next = shift[0];
            state == STOP:  pop = baud_done && !fifo_empty;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            line_q   <= UART_IDLE_LEVEL;
            busy_q   <= 1'b0;
        end else begin
            line_q <= line_next;
            busy_q <= (state != IDLE) || !fifo_empty;
            if (state == IDLE || baud_done) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;
            if (pop) begin
                shift   <= fifo_dout;
                bit_idx <= '0;
            end else if (state == DATA && baud_done) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: vector table, directed corner sequences,
// random traffic against a frame-schedule model, and a slow-baud run.
module tb_uart_tx_engine;

    localparam int CPB      = 16;
    localparam int SLOW_CPB = 10417;
    localparam int AW       = 2;
    localparam int DEPTH    = 4;
    localparam int FRAME    = 10 * CPB;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          tx_busy;
    logic [AW:0]   fifo_count;
    logic          UART_TX;

    logic          s_reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data  = 8'h00;
    logic          s_ready;
    logic          s_busy;
    logic [AW:0]   s_count;
    logic          s_line;

    always #5 sysclk = ~sysclk;

    uart_tx_engine #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .UART_TX    (UART_TX)
    );

    uart_tx_engine #(.CLKS_PER_BIT(SLOW_CPB), .FIFO_AW(AW)) dut_slow (
        .sysclk     (sysclk),
        .reset      (s_reset),
        .tx_data    (s_data),
        .tx_valid   (s_valid),
        .tx_ready   (s_ready),
        .tx_busy    (s_busy),
        .fifo_count (s_count),
        .UART_TX    (s_line)
    );

    int checks = 0;
    int errors = 0;
    int e      = 0;

    // Model: queued bytes with accept edge, and frames with their pop edge
    typedef struct { logic [7:0] b; int acc; } ent_t;
    typedef struct { logic [7:0] b; int p; } frame_t;
    ent_t   mq[$];
    frame_t frames[$];
    int     last_p    = -1000000;
    int     prev_size = 0;
    logic   m_line    = 1'b1;
    logic   m_busy    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h",
                     name, e, act, exp);
        end
    endtask

    function automatic logic line_at(input int t);
        logic r;
        r = 1'b1;
        for (int i = 0; i < frames.size(); i++) begin
            if (t > frames[i].p && t <= frames[i].p + FRAME) begin
                int k;
                logic [7:0] bb;
                k  = (t - frames[i].p - 1) / CPB;
                bb = frames[i].b;
                if (k == 0)      r = 1'b0;
                else if (k == 9) r = 1'b1;
                else             r = bb[k-1];
            end
        end
        return r;
    endfunction

    function automatic logic active_at(input int t);
        logic r;
        r = 1'b0;
        for (int i = 0; i < frames.size(); i++)
            if (t >= frames[i].p && t < frames[i].p + FRAME) r = 1'b1;
        return r;
    endfunction

    task automatic model_edge(input logic v, input logic [7:0] d,
                              input logic r);
        int pre;
        int p;
        if (r) begin
            mq.delete();
            frames.delete();
            last_p    = -1000000;
            prev_size = 0;
            m_line    = 1'b1;
            m_busy    = 1'b0;
            return;
        end
        m_busy = (prev_size > 0) || active_at(e - 1);
        pre = mq.size();
        if (pre > 0) begin
            p = mq[0].acc + 1;
            if (last_p + FRAME > p) p = last_p + FRAME;
            if (p <= e) begin
                frames.push_back('{mq[0].b, e});
                last_p = e;
                void'(mq.pop_front());
            end
        end
        if (v && pre < DEPTH) mq.push_back('{d, e});
        m_line    = line_at(e);
        prev_size = mq.size();
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic r);
        tx_valid = v;
        tx_data  = d;
        reset    = r;
        @(posedge sysclk);
        e++;
        model_edge(v, d, r);
        @(negedge sysclk);
        chk("model_line", UART_TX, m_line);
        chk("model_count", fifo_count, mq.size());
        chk("model_ready", tx_ready, mq.size() != DEPTH);
        chk("model_busy", tx_busy, m_busy);
    endtask

    task automatic idle_to(input int t);
        while (e < t) tick(1'b0, 8'h00, 1'b0);
    endtask

    // Independent line decoder: samples the middle of each bit
    logic [7:0] rx_q[$];
    logic       mon_on = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sr = 8'h00;

    always @(negedge sysclk) begin
        if (reset !== 1'b0) begin
            mon_on <= 1'b0;
        end else if (!mon_on) begin
            if (UART_TX == 1'b0) begin
                mon_on  <= 1'b1;
                mon_cnt <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt % CPB == CPB / 2 && mon_cnt > CPB && mon_cnt < 9 * CPB)
                mon_sr <= {UART_TX, mon_sr[7:1]};
            if (mon_cnt == 9 * CPB + CPB / 2) begin
                rx_q.push_back(mon_sr);
                mon_on <= 1'b0;
            end
        end
    end

    task automatic chk_rx(input string name, input logic [7:0] exp[$]);
        chk({name, "_n"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            chk(name, rx_q[i], exp[i]);
        rx_q.delete();
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic [2:0] cnt;
        logic       rdy;
        logic       line;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[8];
        logic [7:0] exp_q[$];
        logic [7:0] bv;
        logic       seen_low;
        int         n;
        int         rst_at;
        int         rates[8];

        // Reset and idle line
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        chk("rst_line", UART_TX, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_count", fifo_count, 0);
        seen_low = 1'b0;
        repeat (100) begin
            tick(1'b0, 8'h00, 1'b0);
            if (UART_TX !== 1'b1) seen_low = 1'b1;
        end
        chk("idle_line_low", seen_low, 1'b0);

        // Fill the FIFO while idle; sixth push is dropped
        tbl[0] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h01, 3'd1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8'h03, 3'd2, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h04, 3'd3, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h05, 3'd4, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'hFF, 3'd4, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
        rx_q.delete();
        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].v, tbl[i].d, tbl[i].rst);
            chk($sformatf("tbl_count[%0d]", i), fifo_count, tbl[i].cnt);
            chk($sformatf("tbl_ready[%0d]", i), tx_ready, tbl[i].rdy);
            chk($sformatf("tbl_line[%0d]", i), UART_TX, tbl[i].line);
        end
        idle_to(e + 5 * FRAME + 20);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk_rx("full_rx", exp_q);

        // Single byte 0x22: exact bit boundaries and busy fall
        bv = 8'h22;
        tick(1'b1, bv, 1'b0);
        n = e;
        idle_to(n + 1);
        chk("b22_n1_line", UART_TX, 1'b1);
        idle_to(n + 2);
        chk("b22_start_first", UART_TX, 1'b0);
        idle_to(n + 17);
        chk("b22_start_last", UART_TX, 1'b0);
        for (int k = 0; k < 8; k++) begin
            idle_to(n + 18 + 16 * k);
            chk($sformatf("b22_bit%0d_first", k), UART_TX, bv[k]);
            idle_to(n + 33 + 16 * k);
            chk($sformatf("b22_bit%0d_last", k), UART_TX, bv[k]);
        end
        idle_to(n + 146);
        chk("b22_stop", UART_TX, 1'b1);
        idle_to(n + 161);
        chk("b22_busy_hi", tx_busy, 1'b1);
        idle_to(n + 162);
        chk("b22_busy_lo", tx_busy, 1'b0);
        idle_to(n + 170);
        exp_q = '{8'h22};
        chk_rx("b22_rx", exp_q);

        // Back-to-back 0x55, 0xA3 with no gap between frames
        tick(1'b1, 8'h55, 1'b0);
        n = e;
        chk("b2b_count_n", fifo_count, 1);
        tick(1'b1, 8'hA3, 1'b0);
        chk("b2b_count_n1", fifo_count, 1);
        idle_to(n + 160);
        chk("b2b_count_pre", fifo_count, 1);
        idle_to(n + 161);
        chk("b2b_count_pop", fifo_count, 0);
        chk("b2b_stop", UART_TX, 1'b1);
        idle_to(n + 162);
        chk("b2b_nogap", UART_TX, 1'b0);
        idle_to(n + 340);
        exp_q = '{8'h55, 8'hA3};
        chk_rx("b2b_rx", exp_q);

        // Push on the same edge as the STOP->START pop
        tick(1'b1, 8'h11, 1'b0);
        n = e;
        idle_to(n + 50);
        tick(1'b1, 8'h22, 1'b0);
        idle_to(n + 160);
        chk("sim_count_pre", fifo_count, 1);
        tick(1'b1, 8'h33, 1'b0);
        chk("sim_count", fifo_count, 1);
        chk("sim_stop", UART_TX, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
        chk("sim_start", UART_TX, 1'b0);
        idle_to(n + 500);
        exp_q = '{8'h11, 8'h22, 8'h33};
        chk_rx("sim_rx", exp_q);

        // Reset during data bit 3 of 0x0F with two bytes queued
        tick(1'b1, 8'h0F, 1'b0);
        n = e;
        tick(1'b1, 8'hAA, 1'b0);
        tick(1'b1, 8'hBB, 1'b0);
        chk("mid_count", fifo_count, 2);
        idle_to(n + 70);
        chk("mid_bit3", UART_TX, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        chk("mid_rst_line", UART_TX, 1'b1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", tx_busy, 1'b0);
        seen_low = 1'b0;
        repeat (400) begin
            tick(1'b0, 8'h00, 1'b0);
            if (UART_TX !== 1'b1) seen_low = 1'b1;
        end
        chk("mid_no_frames", seen_low, 1'b0);
        rx_q.delete();

        // Random traffic in phases of varying push density
        rates  = '{3, 40, 0, 80, 10, 100, 1, 25};
        rst_at = $urandom_range(1000, 3000);
        for (int i = 0; i < 4000; i++) begin
            logic rv;
            rv = $urandom_range(0, 99) < rates[i / 500];
            tick(rv, 8'($urandom()), 1'(i == rst_at));
        end
        idle_to(e + 5 * FRAME + 20);
        chk("rand_drained", fifo_count, 0);
        rx_q.delete();

        // Full-rate baud divisor: start bit and first two data bits
        repeat (3) tick(1'b0, 8'h00, 1'b0);
        s_reset = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick(1'b0, 8'h00, 1'b0);
        n = e;
        s_valid = 1'b0;
        chk("slow_count_n", s_count, 1);
        idle_to(n + 1);
        chk("slow_n1_line", s_line, 1'b1);
        chk("slow_ready", s_ready, 1'b1);
        idle_to(n + 2);
        chk("slow_start_first", s_line, 1'b0);
        idle_to(n + 2 + SLOW_CPB - 1);
        chk("slow_start_last", s_line, 1'b0);
        chk("slow_busy", s_busy, 1'b1);
        idle_to(n + 2 + SLOW_CPB);
        chk("slow_bit0_first", s_line, 1'b1);
        idle_to(n + 2 + 2 * SLOW_CPB - 1);
        chk("slow_bit0_last", s_line, 1'b1);
        idle_to(n + 2 + 2 * SLOW_CPB);
        chk("slow_bit1_first", s_line, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
